// File: rtl/gene_ticks.sv
// gene_ticks: timebase generator for the digital clock.
// Produces a 50 % seconds square wave, a one-cycle seconds tick,
// a 2x blink wave locked to the seconds wave, and a free-running scan tick.
// The seconds domain supports pause (en), phase restart (resync) and
// an accelerated mode (fast). The scan domain ignores all three.
module gene_ticks #(
    parameter int CLK_FREQ = 100000000,
    parameter int SCAN_HZ  = 1000,
    parameter int FAST_DIV = 1000,
    parameter int CNT_W    = 27,
    parameter int SCAN_W   = 17
) (
    input  logic clk_100mhz,
    input  logic rst_100mhz,
    input  logic en,
    input  logic fast,
    input  logic resync,
    output logic out_1hz,
    output logic tick_1hz,
    output logic blink_2hz,
    output logic tick_scan
);

    // Terminal counts for the seconds phase in both speeds, and for the scan divider.
    localparam logic [CNT_W-1:0]  HALF_SLOW_M1 = CNT_W'(CLK_FREQ / 2 - 1);
    localparam logic [CNT_W-1:0]  HALF_FAST_M1 = CNT_W'(CLK_FREQ / (2 * FAST_DIV) - 1);
    localparam logic [CNT_W-1:0]  Q_SLOW_M1    = CNT_W'(CLK_FREQ / 4 - 1);
    localparam logic [CNT_W-1:0]  Q_FAST_M1    = CNT_W'(CLK_FREQ / (4 * FAST_DIV) - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST    = SCAN_W'(CLK_FREQ / SCAN_HZ - 1);

    logic [CNT_W-1:0]  cnt_reg;
    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [CNT_W-1:0]  half_m1;
    logic [CNT_W-1:0]  q_m1;

    // Active period limits follow the fast input combinationally, so a speed
    // change takes effect on the very next edge.
    always_comb begin
        half_m1 = fast ? HALF_FAST_M1 : HALF_SLOW_M1;
        q_m1    = fast ? Q_FAST_M1    : Q_SLOW_M1;
    end

    // Seconds phase counter with resync > pause > count priority.
    // The wrap test is >= so that a drop to the shorter fast period while the
    // counter is already beyond it wraps immediately instead of overrunning.
    always_ff @(posedge clk_100mhz or posedge rst_100mhz) begin
        if (rst_100mhz) begin
            cnt_reg   <= '0;
            out_1hz   <= 1'b0;
            tick_1hz  <= 1'b0;
            blink_2hz <= 1'b0;
        end else if (resync) begin
            cnt_reg   <= '0;
            out_1hz   <= 1'b0;
            tick_1hz  <= 1'b0;
            blink_2hz <= 1'b0;
        end else if (!en) begin
            tick_1hz  <= 1'b0;
        end else if (cnt_reg >= half_m1) begin
            cnt_reg   <= '0;
            out_1hz   <= ~out_1hz;
            blink_2hz <= ~blink_2hz;
            tick_1hz  <= ~out_1hz;
        end else if (cnt_reg == q_m1) begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
            blink_2hz <= ~blink_2hz;
            tick_1hz  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
            tick_1hz  <= 1'b0;
        end
    end

    // Free-running scan divider; pulses on the wrap cycle only.
    always_ff @(posedge clk_100mhz or posedge rst_100mhz) begin
        if (rst_100mhz) begin
            scan_cnt_reg <= '0;
            tick_scan    <= 1'b0;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
            tick_scan    <= 1'b1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
            tick_scan    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gene_ticks.sv
// tb_gene_ticks: directed bench for gene_ticks with small periods
// (HALF=500/Q=250 normal, HALF=100/Q=50 fast, scan period 10).
module tb_gene_ticks;

    logic clk_100mhz = 1'b0;
    logic rst_100mhz;
    logic en;
    logic fast;
    logic resync;
    logic out_1hz;
    logic tick_1hz;
    logic blink_2hz;
    logic tick_scan;

    int n_cmp  = 0;
    int n_bad  = 0;
    int edge_n = 0;

    gene_ticks #(
        .CLK_FREQ (1000),
        .SCAN_HZ  (100),
        .FAST_DIV (5),
        .CNT_W    (10),
        .SCAN_W   (4)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst_100mhz (rst_100mhz),
        .en         (en),
        .fast       (fast),
        .resync     (resync),
        .out_1hz    (out_1hz),
        .tick_1hz   (tick_1hz),
        .blink_2hz  (blink_2hz),
        .tick_scan  (tick_scan)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at edge %0d: observed %0b expected %0b", tag, edge_n, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk_100mhz);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int target);
        while (edge_n < target) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"},   out_1hz,   1'b0);
        check({tag, "_tick"},  tick_1hz,  1'b0);
        check({tag, "_blink"}, blink_2hz, 1'b0);
        check({tag, "_scan"},  tick_scan, 1'b0);
    endtask

    // Assert reset, confirm outputs clear, release just after an edge so
    // the next rising edge is edge 1.
    task automatic do_reset();
        #1;
        rst_100mhz = 1'b1;
        #1;
        check_all_zero("rst");
        @(posedge clk_100mhz);
        #1;
        rst_100mhz = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        rst_100mhz = 1'b1;
        en = 1'b1;
        fast = 1'b0;
        resync = 1'b0;
        repeat (3) @(posedge clk_100mhz);
        #1;
        check_all_zero("por");
        rst_100mhz = 1'b0;
        edge_n = 0;

        // 1/2: normal free run; cycle-by-cycle against closed-form timing.
        for (int e = 1; e <= 1600; e++) begin
            tick();
            check("t1_tick",  tick_1hz,  (e == 500) || (e == 1500));
            check("t1_out",   out_1hz,   ((e / 500) % 2) == 1);
            check("t1_blink", blink_2hz, ((e / 250) % 2) == 1);
            check("t2_scan",  tick_scan, (e % 10) == 0);
        end

        // 3: pause of 37 cycles covering edges 100..136.
        do_reset();
        run_to(99);
        en = 1'b0;
        for (int e = 100; e <= 136; e++) begin
            tick();
            check("t3_tick_paused", tick_1hz,  1'b0);
            check("t3_scan_paused", tick_scan, (e % 10) == 0);
        end
        en = 1'b1;
        run_to(286);
        check("t3_blink_286", blink_2hz, 1'b0);
        run_to(287);
        check("t3_blink_287", blink_2hz, 1'b1);
        run_to(536);
        check("t3_out_536",  out_1hz,  1'b0);
        check("t3_tick_536", tick_1hz, 1'b0);
        run_to(537);
        check("t3_out_537",  out_1hz,  1'b1);
        check("t3_tick_537", tick_1hz, 1'b1);

        // 4a: fast mode from reset.
        fast = 1'b1;
        do_reset();
        for (int e = 1; e <= 500; e++) begin
            tick();
            check("t4_tick",  tick_1hz,  (e % 200) == 100);
            check("t4_out",   out_1hz,   ((e / 100) % 2) == 1);
            check("t4_blink", blink_2hz, ((e / 50) % 2) == 1);
            check("t4_scan",  tick_scan, (e % 10) == 0);
        end

        // 4b: switch slow->fast at cnt=300, expect wrap on the next edge.
        fast = 1'b0;
        do_reset();
        run_to(300);
        check("t4b_blink_300", blink_2hz, 1'b1);
        fast = 1'b1;
        run_to(301);
        check("t4b_out_301",   out_1hz,   1'b1);
        check("t4b_tick_301",  tick_1hz,  1'b1);
        check("t4b_blink_301", blink_2hz, 1'b0);
        run_to(351);
        check("t4b_blink_351", blink_2hz, 1'b1);
        run_to(400);
        check("t4b_out_400",   out_1hz,   1'b1);
        run_to(401);
        check("t4b_out_401",   out_1hz,   1'b0);
        check("t4b_tick_401",  tick_1hz,  1'b0);
        run_to(500);
        check("t4b_tick_500",  tick_1hz,  1'b0);
        run_to(501);
        check("t4b_out_501",   out_1hz,   1'b1);
        check("t4b_tick_501",  tick_1hz,  1'b1);

        // 5: resync pulse sampled at edge 700 while out_1hz=1.
        fast = 1'b0;
        do_reset();
        run_to(699);
        check("t5_out_699", out_1hz, 1'b1);
        resync = 1'b1;
        run_to(700);
        resync = 1'b0;
        check("t5_out_700",   out_1hz,   1'b0);
        check("t5_blink_700", blink_2hz, 1'b0);
        check("t5_tick_700",  tick_1hz,  1'b0);
        check("t5_scan_700",  tick_scan, 1'b1);
        run_to(710);
        check("t5_scan_710",  tick_scan, 1'b1);
        run_to(949);
        check("t5_blink_949", blink_2hz, 1'b0);
        run_to(950);
        check("t5_blink_950", blink_2hz, 1'b1);
        run_to(1199);
        check("t5_tick_1199", tick_1hz, 1'b0);
        check("t5_out_1199",  out_1hz,  1'b0);
        run_to(1200);
        check("t5_tick_1200", tick_1hz, 1'b1);
        check("t5_out_1200",  out_1hz,  1'b1);

        // 6: asynchronous reset mid-period at cnt=400.
        do_reset();
        run_to(400);
        check("t6_blink_pre", blink_2hz, 1'b1);
        check("t6_scan_pre",  tick_scan, 1'b1);
        #2;
        rst_100mhz = 1'b1;
        #1;
        check_all_zero("t6_async");
        @(posedge clk_100mhz);
        #1;
        rst_100mhz = 1'b0;
        edge_n = 0;
        run_to(499);
        check("t6_tick_499", tick_1hz, 1'b0);
        run_to(500);
        check("t6_tick_500", tick_1hz, 1'b1);
        check("t6_out_500",  out_1hz,  1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gene_ticks.md
# gene_ticks

Parametrised timebase generator for the digital clock. It derives all slow timing from the 100 MHz board clock: a 50 % 1 Hz square wave, a one-cycle seconds tick for the time counters, a 2 Hz blink signal for the time-setting display, and a free-running display-scan tick. It adds pause, phase resync and a fast (accelerated) mode for time-setting and simulation. It replaces the single-output 1 Hz divider and sits between the clock input and the time-keeping and display-scan logic.

## Interface

Parameters:

- CLK_FREQ, 100000000: input clock frequency in Hz.
- SCAN_HZ, 1000: display-scan tick rate in Hz.
- FAST_DIV, 1000: speed-up factor applied to the 1 Hz and 2 Hz outputs when fast=1.
- CNT_W, 27: width of the seconds-phase counter; must hold CLK_FREQ/2-1.
- SCAN_W, 17: width of the scan counter; must hold CLK_FREQ/SCAN_HZ-1.
- Legality: CLK_FREQ divisible by 4*FAST_DIV; CLK_FREQ divisible by SCAN_HZ; CLK_FREQ/SCAN_HZ >= 2.

Ports:

- clk_100mhz, input, 1: system clock, all logic on the rising edge.
- rst_100mhz, input, 1: reset, asynchronous, active-high.
- en, input, 1: 1 = seconds timebase runs; 0 = frozen.
- fast, input, 1: 1 = accelerated timebase.
- resync, input, 1: synchronous restart of the seconds phase.
- out_1hz, output, 1: square wave, period 2*HALF cycles, 50 % duty.
- tick_1hz, output, 1: one-cycle pulse on each rising edge of out_1hz.
- blink_2hz, output, 1: square wave at twice the out_1hz rate, phase-locked to it.
- tick_scan, output, 1: one-cycle pulse every CLK_FREQ/SCAN_HZ cycles.

## Operation

- Period constants:
  - HALF = CLK_FREQ/2 when fast=0.
  - HALF = CLK_FREQ/(2*FAST_DIV) when fast=1.
  - Q = HALF/2.
- Seconds counter cnt (CNT_W bits); all outputs registered.
- Priority per clock: reset, then resync, then en=0, then normal counting.
- Reset: cnt=0, out_1hz=0, tick_1hz=0, blink_2hz=0, scan counter=0, tick_scan=0.
- resync=1: cnt<=0, out_1hz<=0, blink_2hz<=0, tick_1hz<=0. The scan counter is unaffected. This applies even when en=0.
- en=0 (no resync): cnt, out_1hz and blink_2hz hold; tick_1hz<=0.
- Normal counting:
  - If cnt >= HALF-1: cnt<=0, out_1hz toggles, blink_2hz toggles, and tick_1hz<=1 iff out_1hz was 0.
  - Else if cnt == Q-1: cnt<=cnt+1, blink_2hz toggles, tick_1hz<=0.
  - Otherwise: cnt<=cnt+1, tick_1hz<=0.
- The wrap compare is >= (not ==), so switching fast 0->1 while cnt is above the new HALF-1 wraps on the next clock. The period is never lost and the counter never overruns.
- blink_2hz toggles at cnt=Q-1 and at wrap, so it always has four toggles per out_1hz period.
- Scan counter: free-running 0..CLK_FREQ/SCAN_HZ-1 and wraps to 0. tick_scan<=1 on the wrap cycle, else 0. It is independent of en, fast and resync.

## Timing

- Edges are numbered from the first rising edge after reset deassertion, starting at edge 1.
- out_1hz and tick_1hz rise at edge HALF. out_1hz falls at edge 2*HALF.
- tick_1hz rises again at edge 3*HALF, and every 2*HALF edges thereafter.
- tick_1hz is high exactly one cycle, coincident with the out_1hz 0->1 transition; there is no extra latency.
- blink_2hz first rises at edge Q, then toggles every Q edges.
- tick_scan first pulses at edge CLK_FREQ/SCAN_HZ, then every CLK_FREQ/SCAN_HZ edges.
- After resync is sampled high at edge k (en=1, resync then low), the next out_1hz rise is at edge k+HALF.
- A pause of P cycles with en=0 delays every later seconds-domain edge by exactly P cycles.
- Asserting rst_100mhz mid-period clears all outputs immediately, without waiting for a clock edge.

## Test plan

Bench parameters: CLK_FREQ=1000, SCAN_HZ=100, FAST_DIV=5, giving HALF=500 and Q=250 (normal), HALF=100 and Q=50 (fast), scan period 10.

1. Reset release with en=1, fast=0 -> out_1hz rises at edge 500 and falls at 1000. tick_1hz is high only at edges 500 and 1500. blink_2hz toggles at 250, 500, 750 and 1000.
2. Free run -> tick_scan pulses at edges 10, 20, 30, ... and is never high two cycles in a row. Toggling en, fast and resync does not shift it.
3. en=0 for 37 cycles starting at edge 100 -> out_1hz rises at edge 537. tick_1hz is never high while en=0.
4. fast=1 from reset -> out_1hz period is 200 cycles and tick_1hz pulses at edges 100, 300, 500. Switching fast 0->1 at cnt=300 -> wrap on the next edge, then 200-cycle periods.
5. resync pulse at edge 700 while out_1hz=1 -> out_1hz and blink_2hz are 0 after edge 700, and the next tick_1hz is at edge 1200.
6. rst_100mhz asserted asynchronously between edges at cnt=400 -> all outputs 0 immediately. After release, the first tick_1hz is at edge 500 after release.
